// File: rtl/register_bank_mp_pkg.sv
// Shared constants and the dump sequencer state type for the ID-stage register bank.
package register_bank_mp_pkg;

    localparam int DEF_DATA_W       = 32;
    localparam int DEF_NUM_REGS     = 32;
    localparam int DEF_ADDR_W       = 5;
    localparam int DEF_NUM_RD_PORTS = 2;
    localparam int DEF_ZERO_REG     = 1;
    localparam int DEF_BYPASS       = 1;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } dump_state_e;

endpackage

// File: rtl/register_bank_mp_if.sv
// Read, write-back and debug-dump signals of the register bank, bundled for the ID stage.
interface register_bank_mp_if
    import register_bank_mp_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int NUM_RD_PORTS = DEF_NUM_RD_PORTS
) ();

    logic [NUM_RD_PORTS*ADDR_W-1:0] i_rd_addr;
    logic [NUM_RD_PORTS*DATA_W-1:0] o_rd_data;
    logic                           i_wr_en;
    logic [ADDR_W-1:0]              i_wr_addr;
    logic [DATA_W-1:0]              i_wr_data;
    logic                           i_dump_start;
    logic                           i_dump_ready;
    logic                           o_dump_valid;
    logic [DATA_W-1:0]              o_dump_data;
    logic [ADDR_W-1:0]              o_dump_index;
    logic                           o_dump_last;
    logic                           o_dump_busy;

    modport master (
        output i_rd_addr, i_wr_en, i_wr_addr, i_wr_data, i_dump_start, i_dump_ready,
        input  o_rd_data, o_dump_valid, o_dump_data, o_dump_index, o_dump_last, o_dump_busy
    );

    modport slave (
        input  i_rd_addr, i_wr_en, i_wr_addr, i_wr_data, i_dump_start, i_dump_ready,
        output o_rd_data, o_dump_valid, o_dump_data, o_dump_index, o_dump_last, o_dump_busy
    );

endinterface

// File: rtl/register_bank_mp_dump_seq.sv
// Streams every register out under valid/ready; asks the bank for the value of the
// register it will load next and captures it when a beat is started or accepted.
module register_bank_mp_dump_seq
    import register_bank_mp_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_dump_start,
    input  logic              i_dump_ready,
    input  logic [DATA_W-1:0] i_lookup_data,
    output logic [ADDR_W-1:0] o_lookup_addr,
    output logic              o_dump_valid,
    output logic [DATA_W-1:0] o_dump_data,
    output logic [ADDR_W-1:0] o_dump_index,
    output logic              o_dump_last,
    output logic              o_dump_busy
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              active_q, active_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] nextIndex;

    assign nextIndex = index_q + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            index_q  <= '0;
            data_q   <= '0;
            active_q <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            data_q   <= data_d;
            active_q <= active_d;
            last_q   <= last_d;
        end
    end

    // The lookup address is always the register that would be loaded on this edge.
    always_comb begin
        state_d       = state_q;
        index_d       = index_q;
        data_d        = data_q;
        active_d      = active_q;
        last_d        = last_q;
        o_lookup_addr = '0;
        case (state_q)
            ST_IDLE: begin
                if (i_dump_start) begin
                    state_d  = ST_SEND;
                    index_d  = '0;
                    data_d   = i_lookup_data;
                    active_d = 1'b1;
                    last_d   = (LAST_IDX == '0);
                end
            end
            ST_SEND: begin
                o_lookup_addr = nextIndex;
                if (active_q && i_dump_ready) begin
                    if (last_q) begin
                        state_d  = ST_IDLE;
                        active_d = 1'b0;
                        last_d   = 1'b0;
                    end else begin
                        index_d = nextIndex;
                        data_d  = i_lookup_data;
                        last_d  = (nextIndex == LAST_IDX);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_dump_valid = active_q;
    assign o_dump_busy  = active_q;
    assign o_dump_data  = data_q;
    assign o_dump_index = index_q;
    assign o_dump_last  = last_q;

endmodule

// File: rtl/register_bank_mp.sv
// ID-stage register bank: storage, write-back decode, write-first read muxes
// (one per read port plus one feeding the dump sequencer).
module register_bank_mp
    import register_bank_mp_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int NUM_REGS     = DEF_NUM_REGS,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int NUM_RD_PORTS = DEF_NUM_RD_PORTS,
    parameter int ZERO_REG     = DEF_ZERO_REG,
    parameter int BYPASS       = DEF_BYPASS
) (
    input  logic               i_clk,
    input  logic               i_reset,
    register_bank_mp_if.slave  bus
);

    localparam int NUM_MUX = NUM_RD_PORTS + 1;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              wrHit;
    logic [ADDR_W-1:0] muxAddr [NUM_MUX];
    logic [DATA_W-1:0] muxData [NUM_MUX];
    logic [ADDR_W-1:0] dumpAddr;

    function automatic logic addrValid(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < (ADDR_W+1)'(NUM_REGS)) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wrHit = bus.i_wr_en && addrValid(bus.i_wr_addr);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
        end else if (wrHit) begin
            regs_q[bus.i_wr_addr] <= bus.i_wr_data;
        end
    end

    // The last mux is private to the dump sequencer so its lookups never steal a read port.
    always_comb begin
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            muxAddr[p] = bus.i_rd_addr[p*ADDR_W +: ADDR_W];
        end
        muxAddr[NUM_RD_PORTS] = dumpAddr;
    end

    always_comb begin
        for (int m = 0; m < NUM_MUX; m++) begin
            if (!addrValid(muxAddr[m])) begin
                muxData[m] = '0;
            end else if ((BYPASS != 0) && wrHit && (bus.i_wr_addr == muxAddr[m])) begin
                muxData[m] = bus.i_wr_data;
            end else begin
                muxData[m] = regs_q[muxAddr[m]];
            end
        end
    end

    always_comb begin
        bus.o_rd_data = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            bus.o_rd_data[p*DATA_W +: DATA_W] = muxData[p];
        end
    end

    register_bank_mp_dump_seq #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_dump_seq (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_dump_start  (bus.i_dump_start),
        .i_dump_ready  (bus.i_dump_ready),
        .i_lookup_data (muxData[NUM_RD_PORTS]),
        .o_lookup_addr (dumpAddr),
        .o_dump_valid  (bus.o_dump_valid),
        .o_dump_data   (bus.o_dump_data),
        .o_dump_index  (bus.o_dump_index),
        .o_dump_last   (bus.o_dump_last),
        .o_dump_busy   (bus.o_dump_busy)
    );

endmodule

// File: tb/tb_register_bank_mp.sv
// Scoreboard bench for register_bank_mp: a reference bank model predicts read data
// and dump beats, and a negedge monitor compares them against the DUT.
module tb_register_bank_mp;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int NP       = 2;

    typedef struct {
        int                idx;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    register_bank_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD_PORTS(NP)) bus ();

    register_bank_mp #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
        .NUM_RD_PORTS(NP), .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [DATA_W-1:0]    mregs [NUM_REGS];
    bit                   mBusy = 1'b0;
    int                   mIdx  = 0;
    beat_t                dumpQ [$];
    logic [NP*DATA_W-1:0] readQ [$];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural view of a read at this moment: zero register, then write-first, then storage.
    function automatic logic [DATA_W-1:0] expectRead(input int a);
        if (a >= NUM_REGS || a == 0) return '0;
        if (bus.i_wr_en && int'(bus.i_wr_addr) == a) return bus.i_wr_data;
        return mregs[a];
    endfunction

    // Reference model of the bank and the dump stream, advanced once per clock.
    always @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) mregs[r] <= '0;
            mBusy <= 1'b0;
            mIdx  <= 0;
            dumpQ.delete();
        end else begin
            if (bus.i_wr_en && bus.i_wr_addr != 0 && int'(bus.i_wr_addr) < NUM_REGS)
                mregs[bus.i_wr_addr] <= bus.i_wr_data;
            if (!mBusy) begin
                if (bus.i_dump_start) begin
                    mBusy <= 1'b1;
                    mIdx  <= 0;
                    dumpQ.push_back('{0, expectRead(0)});
                end
            end else if (bus.i_dump_ready) begin
                if (mIdx == NUM_REGS - 1) begin
                    mBusy <= 1'b0;
                end else begin
                    mIdx <= mIdx + 1;
                    dumpQ.push_back('{mIdx + 1, expectRead(mIdx + 1)});
                end
            end
        end
    end

    // Monitor: read ports every stimulated cycle, dump beats whenever valid is shown.
    always @(negedge clk) begin
        logic [NP*DATA_W-1:0] exp;
        beat_t                b;
        if (readQ.size() > 0) begin
            exp = readQ.pop_front();
            for (int p = 0; p < NP; p++)
                checkOutput($sformatf("rdPort%0d", p), 64'(bus.o_rd_data[p*DATA_W +: DATA_W]),
                            64'(exp[p*DATA_W +: DATA_W]));
        end
        checkOutput("dumpBusy", 64'(bus.o_dump_busy), 64'(mBusy));
        checkOutput("dumpValid", 64'(bus.o_dump_valid), 64'(mBusy));
        if (bus.o_dump_valid) begin
            if (dumpQ.size() == 0) begin
                checkOutput("dumpBeatExpected", 64'(1), 64'(0));
            end else begin
                b = dumpQ[0];
                checkOutput("dumpIndex", 64'(bus.o_dump_index), 64'(b.idx));
                checkOutput("dumpData", 64'(bus.o_dump_data), 64'(b.data));
                checkOutput("dumpLast", 64'(bus.o_dump_last), 64'(b.idx == NUM_REGS - 1));
                if (bus.i_dump_ready) void'(dumpQ.pop_front());
            end
        end
    end

    function automatic logic [NP*ADDR_W-1:0] rdPair(input int a0, input int a1);
        return {ADDR_W'(a1), ADDR_W'(a0)};
    endfunction

    // Drives one cycle of inputs, records the expected read data, then waits for the next edge.
    task automatic applyStimulus(input logic rst, input logic [NP*ADDR_W-1:0] rd, input logic we,
                                 input int wa, input logic [DATA_W-1:0] wd,
                                 input logic st, input logic rdy);
        logic [NP*DATA_W-1:0] exp;
        reset            = rst;
        bus.i_rd_addr    = rd;
        bus.i_wr_en      = we;
        bus.i_wr_addr    = ADDR_W'(wa);
        bus.i_wr_data    = wd;
        bus.i_dump_start = st;
        bus.i_dump_ready = rdy;
        for (int p = 0; p < NP; p++)
            exp[p*DATA_W +: DATA_W] = expectRead(int'(rd[p*ADDR_W +: ADDR_W]));
        readQ.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NP*ADDR_W-1:0] randRd();
        return rdPair(int'($urandom_range(0, NUM_REGS - 1)), int'($urandom_range(0, NUM_REGS - 1)));
    endfunction

    initial begin
        int cyc;
        reset = 1'b1;
        bus.i_rd_addr = '0; bus.i_wr_en = 1'b0; bus.i_wr_addr = '0; bus.i_wr_data = '0;
        bus.i_dump_start = 1'b0; bus.i_dump_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetIndex", 64'(bus.o_dump_index), 64'(0));
        checkOutput("resetData", 64'(bus.o_dump_data), 64'(0));
        checkOutput("resetLast", 64'(bus.o_dump_last), 64'(0));

        $display("[TB] write-first bypass and zero register");
        applyStimulus(0, rdPair(1, 0), 1, 1, 32'h10, 0, 0);
        applyStimulus(0, rdPair(1, 0), 0, 0, 32'h0, 0, 0);
        applyStimulus(0, rdPair(0, 1), 1, 0, 32'hDEADBEEF, 0, 0);
        applyStimulus(0, rdPair(0, 0), 0, 0, 32'h0, 0, 0);
        applyStimulus(0, rdPair(0, 0), 1, 2, 32'h4, 0, 0);
        applyStimulus(0, rdPair(2, 0), 1, 3, 32'hFFFF0000, 0, 0);
        applyStimulus(0, rdPair(2, 3), 0, 0, 32'h0, 0, 0);
        applyStimulus(0, rdPair(3, 3), 0, 0, 32'h0, 0, 0);
        for (int r = 4; r < NUM_REGS; r++)
            applyStimulus(0, randRd(), 1, r, $urandom, 0, 0);

        $display("[TB] full dump with ready held high");
        applyStimulus(0, randRd(), 0, 0, 32'h0, 1, 1);
        for (int i = 0; i < NUM_REGS + 2; i++)
            applyStimulus(0, randRd(), 0, 0, 32'h0, 0, 1);
        checkOutput("dumpDrained", 64'(dumpQ.size()), 64'(0));

        $display("[TB] dump with stalls and a write racing beat 5");
        applyStimulus(0, randRd(), 0, 0, 32'h0, 1, 1);
        cyc = 0;
        while (mBusy && cyc < 200) begin
            logic rdy;
            rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
            if (mIdx == 4 && rdy) applyStimulus(0, rdPair(5, 4), 1, 5, 32'h55, 0, rdy);
            else                  applyStimulus(0, randRd(), 0, 0, 32'h0, 0, rdy);
            cyc++;
        end
        checkOutput("stallDumpDone", 64'(mBusy), 64'(0));

        $display("[TB] restart ignored, reset mid-dump");
        applyStimulus(0, randRd(), 0, 0, 32'h0, 1, 1);
        cyc = 0;
        while (!(mBusy && mIdx == 10) && cyc < 100) begin
            applyStimulus(0, randRd(), $urandom_range(0, 1), int'($urandom_range(1, NUM_REGS - 1)),
                          $urandom, 1, $urandom_range(0, 1));
            cyc++;
        end
        checkOutput("reachedBeat10", 64'(mIdx), 64'(10));
        applyStimulus(1, randRd(), 0, 0, 32'h0, 0, 1);
        for (int i = 0; i < 4; i++)
            applyStimulus(0, randRd(), 0, 0, 32'h0, 0, 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++)
            applyStimulus(0, randRd(), $urandom_range(0, 1), int'($urandom_range(0, NUM_REGS - 1)),
                          $urandom, ($urandom_range(0, 19) == 0), $urandom_range(0, 1));
        for (int i = 0; i < NUM_REGS + 4; i++)
            applyStimulus(0, randRd(), 0, 0, 32'h0, 0, 1);
        checkOutput("finalIdle", 64'(bus.o_dump_busy), 64'(0));

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
